// File: rtl/frame_detector.sv
// frame_detector: framed-packet receiver with CRC-16/CCITT check, output FIFO and
// per-channel bit serializer. Define FRAME_DET_GRAY_EN to Gray-code serialized words.
module frame_detector #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          MAX_WORDS    = 8,
  parameter logic [15:0] HEADER_WORD  = 16'hE0E0,
  parameter logic [15:0] TRAILER_WORD = 16'h0E0E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  data_vld,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid_o,
  output logic        crc_err
);

  localparam logic [2:0] ST_HUNT   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_CHAN   = 3'd2;
  localparam logic [2:0] ST_RX     = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int STAGE_N = MAX_WORDS + 2;
  localparam int CW      = $clog2(MAX_WORDS + 3);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS + 2);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] n_q, n_d;
  logic [7:0]    chan_q, chan_d;
  logic [15:0]   rx_crc_q, rx_crc_d;
  logic [15:0]   crc_q, crc_d;
  logic          crc_valid_q, crc_valid_d;
  logic          crc_err_q, crc_err_d;
  logic [15:0]   stage_q [STAGE_N];
  logic          stage_we;
  logic [15:0]   crc_next;
  logic          space_ok;
  logic          push;

  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill;
  logic          pop;

  logic [15:0]   shift_q;
  logic [7:0]    ser_chan_q;
  logic [3:0]    bit_q;
  logic          busy_q;
  logic [23:0]   head;
  logic [15:0]   head_enc;

  // CRC-16/CCITT (poly 0x1021), one 16-bit word folded in MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] word);
    logic [15:0] c;
    c = crc_in;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ word[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_next = crc16_word(crc_q, stage_q[idx_q]);
  assign fill     = wr_ptr_q - rd_ptr_q;
  assign space_ok = ({1'b0, fill} + (AW+2)'(n_q)) <= (AW+2)'(FIFO_DEPTH);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    n_d         = n_q;
    chan_d      = chan_q;
    rx_crc_d    = rx_crc_q;
    crc_d       = crc_q;
    crc_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    stage_we    = 1'b0;
    push        = 1'b0;
    case (state_q)
      ST_HUNT: if (data_in == HEADER_WORD) state_d = ST_HDR;
      ST_HDR:  state_d = (data_in == HEADER_WORD) ? ST_CHAN : ST_HUNT;
      ST_CHAN: begin
        if (data_in != HEADER_WORD) begin
          if (data_in[15:8] == 8'h00 && data_in[7:0] != 8'h00) begin
            chan_d  = data_in[7:0];
            cnt_d   = '0;
            state_d = ST_RX;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_RX: begin
        if (cnt_q >= CW'(3) && data_in == TRAILER_WORD &&
            stage_q[cnt_q - CW'(1)] == TRAILER_WORD) begin
          n_d      = cnt_q - CW'(2);
          rx_crc_d = stage_q[cnt_q - CW'(2)];
          idx_d    = '0;
          crc_d    = '0;
          state_d  = ST_CHECK;
        end else if (cnt_q == LAST_CNT) begin
          // One more word would reach MAX_WORDS+3 with no trailer seen.
          state_d = ST_HUNT;
        end else begin
          stage_we = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        if (idx_q == n_q - CW'(1)) begin
          if (crc_next != rx_crc_q || !space_ok) begin
            crc_err_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            idx_d   = '0;
            state_d = ST_COMMIT;
          end
        end else begin
          idx_d = idx_q + CW'(1);
          crc_d = crc_next;
        end
      end
      ST_COMMIT: begin
        push = 1'b1;
        if (idx_q == n_q - CW'(1)) begin
          crc_valid_d = 1'b1;
          state_d     = ST_HUNT;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is only ever updated with non-blocking assignments.
    if (rst) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      chan_q      <= '0;
      rx_crc_q    <= '0;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      chan_q      <= chan_d;
      rx_crc_q    <= rx_crc_d;
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
      crc_err_q   <= crc_err_d;
    end
  end

  // NOTE: data arrays have no reset; the FSM and FIFO pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (stage_we) stage_q[cnt_q] <= data_in;
    if (push && !fifo_full) fifo_mem[wr_ptr_q[AW-1:0]] <= {chan_q, stage_q[idx_q]};
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop        = !fifo_empty && (!busy_q || bit_q == 4'd15);
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

`ifdef FRAME_DET_GRAY_EN
  assign head_enc = head[15:0] ^ (head[15:0] >> 1);
`else
  assign head_enc = head[15:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !fifo_full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)                rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Loading on the 16th bit lets consecutive entries stream without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      ser_chan_q <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
    end else if (pop) begin
      shift_q    <= head_enc;
      ser_chan_q <= head[23:16];
      bit_q      <= '0;
      busy_q     <= 1'b1;
    end else if (busy_q) begin
      shift_q <= {shift_q[14:0], 1'b0};
      bit_q   <= bit_q + 4'd1;
      if (bit_q == 4'd15) busy_q <= 1'b0;
    end
  end

  assign data_out    = busy_q ? ({8{shift_q[15]}} & ser_chan_q) : 8'h00;
  assign data_vld    = busy_q ? ser_chan_q : 8'h00;
  assign crc_valid_o = crc_valid_q;
  assign crc_err     = crc_err_q;

endmodule

// File: tb/tb_frame_detector.sv
// tb_frame_detector: directed and random frames checked against a word-level model
// of framing, CRC (polynomial long division) and per-channel serial output.
module tb_frame_detector;

  localparam logic [15:0] HDR  = 16'hE0E0;
  localparam logic [15:0] TRL  = 16'h0E0E;
  localparam int          MAXW = 8;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [7:0]  data_out;
  logic [7:0]  data_vld;
  logic        fifo_empty;
  logic        fifo_full;
  logic        crc_valid_o;
  logic        crc_err;

  frame_detector dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_vld   (data_vld),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .crc_valid_o(crc_valid_o),
    .crc_err    (crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  chan;
    logic [15:0] word;
  } ent_t;

  ent_t        exp_q [$];
  logic [15:0] pay [MAXW];
  int          checks     = 0;
  int          errors     = 0;
  int          exp_valid  = 0;
  int          exp_err    = 0;
  int          valid_seen = 0;
  int          err_seen   = 0;
  int          bit_n      = 0;
  int          run_len [8];
  int          last_run [8];
  logic [15:0] mon_acc;
  logic [15:0] last_word;
  logic        mon_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // CRC as the remainder of (message * x^16) divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_ref(input int n);
    logic [16:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < n * 16 + 16; i++) begin
      b = (i < n * 16) ? pay[i / 16][15 - (i % 16)] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] enc_ref(input logic [15:0] w);
`ifdef FRAME_DET_GRAY_EN
    return w ^ (w >> 1);
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    do w = 16'($urandom); while (w == HDR || w == TRL);
    return w;
  endfunction

  task automatic drive(input logic [15:0] w);
    data_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] chan_word, input int n, input logic [15:0] crc_xor,
                            input int extra_hdr, input bit drop);
    logic [15:0] crc_sent;
    ent_t        e;
    crc_sent = crc_ref(n) ^ crc_xor;
    while (crc_sent == HDR || crc_sent == TRL) begin
      pay[0]   = rand_word();
      crc_sent = crc_ref(n) ^ crc_xor;
    end
    drive(HDR);
    drive(HDR);
    for (int i = 0; i < extra_hdr; i++) drive(HDR);
    drive(chan_word);
    for (int i = 0; i < n; i++) drive(pay[i]);
    drive(crc_sent);
    drive(TRL);
    drive(TRL);
    if (chan_word[15:8] == 8'h00 && chan_word[7:0] != 8'h00) begin
      if (crc_sent != crc_ref(n) || drop) begin
        exp_err++;
      end else begin
        exp_valid++;
        for (int i = 0; i < n; i++) begin
          e.chan = chan_word[7:0];
          e.word = enc_ref(pay[i]);
          exp_q.push_back(e);
        end
      end
    end
    repeat (2 * n + 4) drive(16'h0000);
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (!(fifo_empty && data_vld == 8'h00) && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_drain_timeout"}, 32'(cyc < 600), 32'd1);
    repeat (3) drive(16'h0000);
    check({tag, "_model_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic verify_counts(input string tag);
    check({tag, "_valid_pulses"}, 32'(valid_seen), 32'(exp_valid));
    check({tag, "_err_pulses"}, 32'(err_seen), 32'(exp_err));
  endtask

  // Output monitor: rebuilds each serialized word and compares it with the model queue.
  always @(negedge clk) begin
    if (rst) begin
      bit_n = 0;
      for (int i = 0; i < 8; i++) run_len[i] = 0;
    end else begin
      check("unselected_data", 32'(data_out & ~data_vld), 32'd0);
      check("pulse_overlap", 32'(crc_valid_o & crc_err), 32'd0);
      if (crc_valid_o) valid_seen++;
      if (crc_err) err_seen++;
      for (int i = 0; i < 8; i++) begin
        if (data_vld[i]) run_len[i]++;
        else if (run_len[i] != 0) begin
          last_run[i] = run_len[i];
          run_len[i]  = 0;
        end
      end
      if (data_vld != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("spurious_vld", 32'(data_vld), 32'd0);
        end else begin
          check("vld_chan", 32'(data_vld), 32'(exp_q[0].chan));
          mon_b = |(data_out & data_vld);
          check("broadcast", 32'(data_out), 32'(mon_b ? data_vld : 8'h00));
          mon_acc = {mon_acc[14:0], mon_b};
          bit_n++;
          if (bit_n == 16) begin
            check("serial_word", 32'(mon_acc), 32'(exp_q[0].word));
            last_word = mon_acc;
            void'(exp_q.pop_front());
            bit_n = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] cw;
    logic [15:0] x;
    logic [15:0] t1_exp;
    logic [15:0] t3_exp;
    int          n;
    int          cyc;

    for (int i = 0; i < 8; i++) begin
      run_len[i]  = 0;
      last_run[i] = 0;
    end
    rst     = 1'b1;
    data_in = 16'h0000;
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_vld", 32'(data_vld), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_pulses", 32'({crc_valid_o, crc_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word, extra header skipped in CHAN.
    pay[0] = 16'hA55A;
    send_frame(16'h0001, 1, 16'h0000, 1, 1'b0);
    wait_drain("t1");
    verify_counts("t1");
`ifdef FRAME_DET_GRAY_EN
    t1_exp = 16'hF7F7;
    t3_exp = 16'h1B2E;
`else
    t1_exp = 16'hA55A;
    t3_exp = 16'h1234;
`endif
    check("t1_word", 32'(last_word), 32'(t1_exp));
    check("t1_run", 32'(last_run[0]), 32'd16);

    // Eight words stream contiguously on channel 1.
    pay[0] = 16'h0123; pay[1] = 16'h4567; pay[2] = 16'h89AB; pay[3] = 16'hCDEF;
    pay[4] = 16'hFEDC; pay[5] = 16'hBA98; pay[6] = 16'h7654; pay[7] = 16'h3210;
    send_frame(16'h0002, 8, 16'h0000, 0, 1'b0);
    wait_drain("t2");
    verify_counts("t2");
    check("t2_run", 32'(last_run[1]), 32'd128);

    pay[0] = 16'h1234;
    send_frame(16'h0004, 1, 16'h0000, 0, 1'b0);
    wait_drain("t3a");
    check("t3a_word", 32'(last_word), 32'(t3_exp));
    for (int i = 0; i < MAXW; i++) pay[i] = 16'hA5A5;
    send_frame(16'h0010, 8, 16'h0000, 0, 1'b0);
    wait_drain("t3b");
    verify_counts("t3");
    check("t3b_run", 32'(last_run[4]), 32'd128);

    // Received CRC forced to FFFF.
    pay[0] = 16'h1234;
    send_frame(16'h0004, 1, crc_ref(1) ^ 16'hFFFF, 0, 1'b0);
    check("t4_empty", 32'(fifo_empty), 32'd1);
    wait_drain("t4");
    verify_counts("t4");

    // Invalid channel word, then a frame that never sends a trailer.
    pay[0] = 16'h5555; pay[1] = 16'h6666;
    send_frame(16'h0300, 2, 16'h0000, 0, 1'b0);
    drive(HDR);
    drive(HDR);
    drive(16'h0001);
    for (int i = 0; i < 9; i++) drive(rand_word());
    repeat (6) drive(16'h0000);
    wait_drain("t5");
    verify_counts("t5");

    // Three maximal frames close together: the third finds too little FIFO space.
    for (int i = 0; i < MAXW; i++) pay[i] = rand_word();
    send_frame(16'h0001, 8, 16'h0000, 0, 1'b0);
    for (int i = 0; i < MAXW; i++) pay[i] = rand_word();
    send_frame(16'h0003, 8, 16'h0000, 0, 1'b0);
    for (int i = 0; i < MAXW; i++) pay[i] = rand_word();
    send_frame(16'h0008, 8, 16'h0000, 0, 1'b1);
    wait_drain("burst");
    verify_counts("burst");

    // Reset while a frame is being serialized.
    for (int i = 0; i < 4; i++) pay[i] = rand_word();
    send_frame(16'h0001, 4, 16'h0000, 0, 1'b0);
    cyc = 0;
    while (data_vld == 8'h00 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t6_serial_started", 32'(data_vld != 8'h00), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_data_out", 32'(data_out), 32'd0);
    check("t6_rst_data_vld", 32'(data_vld), 32'd0);
    check("t6_rst_empty", 32'(fifo_empty), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pay[0] = rand_word();
    pay[1] = rand_word();
    send_frame(16'h0081, 2, 16'h0000, 0, 1'b0);
    wait_drain("t6");
    verify_counts("t6");

    // Random frames: mixed lengths, channel masks, bad CRCs and bad channel words.
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) pay[i] = rand_word();
      if ($urandom_range(0, 4) == 0) begin
        cw = {8'($urandom_range(1, 255)), 8'($urandom)};
        if (cw == HDR) cw = 16'h0300;
      end else begin
        cw = {8'h00, 8'($urandom_range(1, 255))};
      end
      x = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      send_frame(cw, n, x, $urandom_range(0, 2), 1'b0);
      wait_drain("rand");
      verify_counts("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
